// File: rtl/stretch_mc.sv
// Multi-channel pulse stretcher: one-clock strobes become len-clock high levels (one-shot, retrigger or queued train).
// Strobe-to-output latency 1 clock; no backpressure, strobes that cannot be honoured set the sticky ov flag.
module stretch_mc #(
    parameter int CH    = 4,
    parameter int WBITS = 8,
    parameter int PBITS = 3
) (
    input  logic             c,
    input  logic             rn,
    input  logic [CH-1:0]    n,
    input  logic [WBITS-1:0] len,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [CH-1:0]    w,
    output logic [CH-1:0]    ov
);

    // ACTIVE owns bit 0 so the output is a flop bit, not a decode.
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACTIVE = 2'b01;
    localparam logic [1:0] S_GAP    = 2'b10;

    localparam logic [1:0] M_RETRIG = 2'd1;
    localparam logic [1:0] M_QUEUE  = 2'd2;

    // len=0 wraps to all-ones, which yields a 2^WBITS-clock pulse.
    logic [WBITS-1:0] len_m1;
    assign len_m1 = len - WBITS'(1);

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [1:0]       st, st_nx;
        logic [WBITS-1:0] cnt, cnt_nx;
        logic [PBITS-1:0] pend, pend_nx;
        logic             ov_q;
        logic             drop;

        always_comb begin
            st_nx   = st;
            cnt_nx  = cnt;
            pend_nx = pend;
            drop    = 1'b0;
            case (st)
                S_IDLE: begin
                    if (n[gi]) begin
                        st_nx  = S_ACTIVE;
                        cnt_nx = len_m1;
                    end
                end
                S_ACTIVE: begin
                    if (n[gi] && mode == M_RETRIG) begin
                        cnt_nx = len_m1;
                    end else begin
                        if (n[gi]) begin
                            if (mode == M_QUEUE && pend != '1)
                                pend_nx = pend + PBITS'(1);
                            else
                                drop = 1'b1;
                        end
                        // A strobe on the last cycle is already counted in pend_nx here.
                        if (cnt != '0)
                            cnt_nx = cnt - WBITS'(1);
                        else
                            st_nx = (pend_nx != '0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    st_nx  = S_ACTIVE;
                    cnt_nx = len_m1;
                    if (!(n[gi] && mode == M_QUEUE))
                        pend_nx = pend - PBITS'(1);
                    if (n[gi] && (mode == 2'd0 || mode == 2'd3))
                        drop = 1'b1;
                end
                default: st_nx = S_IDLE;
            endcase
        end

        always_ff @(posedge c or negedge rn) begin
            if (!rn) begin
                st   <= S_IDLE;
                cnt  <= '0;
                pend <= '0;
                ov_q <= 1'b0;
            end else begin
                st   <= st_nx;
                cnt  <= cnt_nx;
                pend <= pend_nx;
                ov_q <= drop | (ov_q & ~clr);
            end
        end

        assign w[gi]  = st[0];
        assign ov[gi] = ov_q;
    end

endmodule

// File: tb/tb_stretch_mc.sv
// Bench for stretch_mc: event-level reference model feeding a per-cycle scoreboard, plus directed pulse-shape counts.
module tb_stretch_mc;
    localparam int CH    = 4;
    localparam int WBITS = 8;
    localparam int PBITS = 3;
    localparam int PMAX  = (1 << PBITS) - 1;

    logic             c = 1'b0;
    logic             rn = 1'b0;
    logic [CH-1:0]    n = '0;
    logic [WBITS-1:0] len = WBITS'(5);
    logic [1:0]       mode = 2'd0;
    logic             clr = 1'b0;
    logic [CH-1:0]    w;
    logic [CH-1:0]    ov;

    stretch_mc #(.CH(CH), .WBITS(WBITS), .PBITS(PBITS)) dut (
        .c(c), .rn(rn), .n(n), .len(len), .mode(mode), .clr(clr), .w(w), .ov(ov)
    );

    always #5 c = ~c;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [CH-1:0] w;
        logic [CH-1:0] ov;
    } exp_t;
    exp_t exp_q[$];

    // Model: remaining high clocks, queued pulses, one-clock gap flag, sticky flag.
    int   m_rem  [CH];
    int   m_pend [CH];
    bit   m_gap  [CH];
    bit   m_ov   [CH];
    int   m_len;
    bit   m_drop;
    bit   m_s;
    exp_t m_e;

    always @(posedge c or negedge rn) begin
        if (!rn) begin
            for (int i = 0; i < CH; i++) begin
                m_rem[i] = 0; m_pend[i] = 0; m_gap[i] = 0; m_ov[i] = 0;
            end
            exp_q.delete();
        end else begin
            m_len = (len == 0) ? (1 << WBITS) : int'(len);
            m_e = '0;
            for (int i = 0; i < CH; i++) begin
                m_drop = 0;
                m_s = n[i];
                if (m_gap[i]) begin
                    m_gap[i] = 0;
                    m_rem[i] = m_len;
                    if (!(m_s && mode == 2)) m_pend[i]--;
                    if (m_s && (mode == 0 || mode == 3)) m_drop = 1;
                end else if (m_rem[i] > 0) begin
                    if (m_s && mode == 1) begin
                        m_rem[i] = m_len;
                    end else begin
                        if (m_s && mode == 2 && m_pend[i] < PMAX) m_pend[i]++;
                        else if (m_s) m_drop = 1;
                        m_rem[i]--;
                        if (m_rem[i] == 0 && m_pend[i] > 0) m_gap[i] = 1;
                    end
                end else if (m_s) begin
                    m_rem[i] = m_len;
                end
                if (m_drop) m_ov[i] = 1;
                else if (clr) m_ov[i] = 0;
                m_e.w[i]  = (m_rem[i] > 0);
                m_e.ov[i] = m_ov[i];
            end
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compare every presented cycle, and keep pulse-shape counters.
    int   hi_cnt [CH];
    int   rises  [CH];
    logic [CH-1:0] w_prev = '0;
    exp_t mon_e;

    initial for (int i = 0; i < CH; i++) begin hi_cnt[i] = 0; rises[i] = 0; end

    always @(negedge c) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_w", 32'(w), 32'(mon_e.w));
            chk("sb_ov", 32'(ov), 32'(mon_e.ov));
        end
        for (int i = 0; i < CH; i++) begin
            if (w[i] === 1'b1) hi_cnt[i]++;
            if (w[i] === 1'b1 && w_prev[i] !== 1'b1) rises[i]++;
        end
        w_prev = w;
    end

    int base_hi [CH];
    int base_r  [CH];

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) step();
    endtask

    task automatic strobe(input logic [CH-1:0] m);
        n = m;
        step();
        n = '0;
    endtask

    task automatic snap();
        for (int i = 0; i < CH; i++) begin
            base_hi[i] = hi_cnt[i];
            base_r[i]  = rises[i];
        end
    endtask

    task automatic chk_shape(input string name, input int ch, input int hi, input int r);
        chk({name, "_hi"}, 32'(hi_cnt[ch] - base_hi[ch]), 32'(hi));
        chk({name, "_rises"}, 32'(rises[ch] - base_r[ch]), 32'(r));
    endtask

    logic [CH-1:0] nn;

    initial begin
        step();
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        step();
        rn = 1'b1;
        wait_cyc(2);

        len = WBITS'(5); mode = 2'd0;
        snap(); strobe(4'b0001); wait_cyc(10);
        chk_shape("len5", 0, 5, 1);
        chk_shape("len5_ch1", 1, 0, 0);

        len = WBITS'(1);
        snap(); strobe(4'b0001); wait_cyc(4);
        chk_shape("len1", 0, 1, 1);

        len = '0;
        snap(); strobe(4'b0001); wait_cyc(262);
        chk_shape("len0", 0, 256, 1);

        len = WBITS'(10); mode = 2'd0;
        snap(); strobe(4'b0001); wait_cyc(2); strobe(4'b0001); wait_cyc(12);
        chk_shape("m0", 0, 10, 1);
        chk("m0_ov", 32'(ov[0]), 32'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("m0_clr", 32'(ov[0]), 32'd0);
        strobe(4'b0001); step();
        n = 4'b0001; clr = 1'b1; step(); n = '0; clr = 1'b0;
        chk("m0_clr_vs_set", 32'(ov[0]), 32'd1);

        chk("pre_rst_w", 32'(w[0]), 32'd1);
        rn = 1'b0; #1;
        chk("async_rst_w", 32'(w), 32'd0);
        chk("async_rst_ov", 32'(ov), 32'd0);
        step(); rn = 1'b1; step();

        len = WBITS'(8); mode = 2'd1;
        snap(); strobe(4'b0001); wait_cyc(4); strobe(4'b0001); wait_cyc(6); strobe(4'b0001);
        wait_cyc(30);
        chk_shape("m1", 0, 20, 1);
        chk("m1_ov", 32'(ov[0]), 32'd0);

        len = WBITS'(4); mode = 2'd2;
        snap(); strobe(4'b0001); strobe(4'b0001); strobe(4'b0001); wait_cyc(20);
        chk_shape("m2", 0, 12, 3);

        len = WBITS'(10);
        snap(); repeat (9) strobe(4'b0001); wait_cyc(100);
        chk_shape("m2_sat", 0, 80, 8);
        chk("m2_sat_ov", 32'(ov[0]), 32'd1);

        clr = 1'b1; step(); clr = 1'b0;
        len = WBITS'(3);
        snap(); strobe(4'b1111); strobe(4'b0100); strobe(4'b0100); wait_cyc(20);
        chk_shape("mc_ch0", 0, 3, 1);
        chk_shape("mc_ch1", 1, 3, 1);
        chk_shape("mc_ch3", 3, 3, 1);
        chk_shape("mc_ch2", 2, 9, 3);
        chk("mc_ov", 32'(ov), 32'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 97 == 0) begin
                mode = 2'($urandom_range(0, 3));
                len  = ($urandom_range(0, 19) == 0) ? '0 : WBITS'($urandom_range(1, 12));
            end
            if (cyc == 1500) begin
                rn = 1'b0; #2; rn = 1'b1;
            end
            for (int i = 0; i < CH; i++) nn[i] = ($urandom_range(0, 99) < 12);
            n   = nn;
            clr = ($urandom_range(0, 49) == 0);
            step();
        end
        n = '0; clr = 1'b0;
        wait_cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
